// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and an internal oversample tick divider.
// Bytes are offered over a valid/ready handshake; framing and overrun errors are pulsed.
module uart_receiver #(
    parameter int unsigned SYS_CLK  = 30000000,
    parameter int unsigned BAUDRATE = 9600,
    parameter int unsigned TICK_DIV = SYS_CLK / (BAUDRATE * 16)
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             r_sync1;
    logic             r_rx_s;
    logic             r_prev_s;
    logic [3:0]       r_os_cnt;
    logic [3:0]       w_os_nx;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nx;
    logic [7:0]       r_shreg;
    logic [7:0]       w_sh_nx;
    logic [7:0]       r_rx_data;
    logic [7:0]       w_data_nx;
    logic             r_rx_valid;
    logic             w_valid_nx;
    logic             r_frame_err;
    logic             w_ferr_nx;
    logic             r_overrun;
    logic             w_ovr_nx;

    assign w_tick    = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Oversample tick divider, input synchroniser and tick-rate edge history
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_prev_s   <= 1'b1;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            r_sync1    <= rx;
            r_rx_s     <= r_sync1;
            if (w_tick) begin
                r_prev_s <= r_rx_s;
            end
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_os_cnt    <= w_os_nx;
            r_bit_cnt   <= w_bit_nx;
            r_shreg     <= w_sh_nx;
            r_rx_data   <= w_data_nx;
            r_rx_valid  <= w_valid_nx;
            r_frame_err <= w_ferr_nx;
            r_overrun   <= w_ovr_nx;
        end
    end

    // Next-state logic; an acceptance in the stop-sample cycle frees the buffer for the new byte
    always_comb begin
        w_state_nx = r_state;
        w_os_nx    = r_os_cnt;
        w_bit_nx   = r_bit_cnt;
        w_sh_nx    = r_shreg;
        w_data_nx  = r_rx_data;
        w_valid_nx = r_rx_valid & ~rx_ready;
        w_ferr_nx  = 1'b0;
        w_ovr_nx   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s && r_prev_s) begin
                        w_state_nx = S_START;
                        w_os_nx    = '0;
                    end
                end
                S_START: begin
                    w_os_nx = r_os_cnt + 4'd1;
                    if (r_os_cnt == 4'd7) begin
                        if (!r_rx_s) begin
                            w_state_nx = S_DATA;
                            w_os_nx    = '0;
                            w_bit_nx   = '0;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    w_os_nx = r_os_cnt + 4'd1;
                    if (r_os_cnt == 4'd15) begin
                        w_sh_nx = {r_rx_s, r_shreg[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nx = S_STOP;
                            w_os_nx    = '0;
                        end else begin
                            w_bit_nx = r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    w_os_nx = r_os_cnt + 4'd1;
                    if (r_os_cnt == 4'd15) begin
                        w_state_nx = S_IDLE;
                        if (r_rx_s) begin
                            if (!r_rx_valid || rx_ready) begin
                                w_data_nx  = r_shreg;
                                w_valid_nx = 1'b1;
                            end else begin
                                w_ovr_nx = 1'b1;
                            end
                        end else begin
                            w_ferr_nx = 1'b1;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected events,
// a negedge monitor pops and compares each byte, frame error and overrun.
module tb_uart_receiver;

    localparam int unsigned BIT_CYC = 64;

    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         lat;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   t_edge   = 0;
    logic prev_v   = 1'b0;
    bit   chk_clear = 1'b0;

    uart_receiver #(
        .SYS_CLK (64000),
        .BAUDRATE(1000)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic handle(input int kind, input logic [7:0] val);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d value 0x%0h, expected none (cycle %0d)",
                     kind, val, cyc);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == K_FERR) begin
                chk("ferr_no_valid", 32'(rx_valid), 32'd0);
            end else begin
                chk("event_data", 32'(val), 32'(e.data));
            end
            if (e.lat) begin
                chk("valid_latency_in_window",
                    32'((cyc - t_edge >= 604) && (cyc - t_edge <= 620)), 32'd1);
            end
            if (kind == K_DATA && rx_ready) begin
                chk_clear = 1'b1;
            end
        end
    endtask

    // Monitor: detects byte deliveries and error pulses, compares against the scoreboard
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (chk_clear) begin
                chk_clear = 1'b0;
                chk("valid_clears_after_accept", 32'(rx_valid), 32'd0);
            end
            if (rx_valid && !prev_v) handle(K_DATA, rx_data);
            if (frame_err)           handle(K_FERR, 8'h00);
            if (overrun)             handle(K_OVR, rx_data);
        end
        prev_v = rx_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx     = 1'b0;
        t_edge = cyc;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(BIT_CYC);
        end
        rx = stop;
        wait_cyc(BIT_CYC);
        rx = 1'b1;
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input bit lat);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        wait_cyc(4);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        wait_cyc(2000);
        chk("idle_rx_data", 32'(rx_data), 32'h00);
        chk("idle_rx_valid", 32'(rx_valid), 32'd0);

        expect_ev(K_DATA, 8'hA5, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_cyc(100);

        rx_ready = 1'b0;
        expect_ev(K_DATA, 8'h3C, 1'b0);
        expect_ev(K_OVR, 8'h3C, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        wait_cyc(100);
        chk("overrun_keeps_data", 32'(rx_data), 32'h3C);
        chk("overrun_keeps_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        wait_cyc(2);
        chk("drain_valid_low", 32'(rx_valid), 32'd0);
        wait_cyc(50);

        expect_ev(K_FERR, 8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        wait_cyc(2 * BIT_CYC);
        chk("post_ferr_valid", 32'(rx_valid), 32'd0);
        expect_ev(K_DATA, 8'h0F, 1'b0);
        send_byte(8'h0F, 1'b1);
        wait_cyc(100);

        rx = 1'b0;
        wait_cyc(16);
        rx = 1'b1;
        wait_cyc(300);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);
        expect_ev(K_DATA, 8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_cyc(100);

        // Reset lands in the last (high) data bit, so the aborted frame leaves no falling edge behind
        fork
            send_byte(8'h81, 1'b1);
            begin
                wait_cyc(BIT_CYC * 8 + 8);
                rst = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
            end
        join
        wait_cyc(100);
        chk("abort_no_valid", 32'(rx_valid), 32'd0);
        expect_ev(K_DATA, 8'h7E, 1'b0);
        send_byte(8'h7E, 1'b1);
        wait_cyc(100);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
